// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared digit count, BCD limit and active-low {g,f,e,d,c,b,a} segment patterns
package bcd_disp_pkg;
    typedef logic [6:0] seg_t;
    localparam int DIGITS = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam seg_t SEG_0 = 7'b1000000;
    localparam seg_t SEG_1 = 7'b1111001;
    localparam seg_t SEG_2 = 7'b0100100;
    localparam seg_t SEG_3 = 7'b0110000;
    localparam seg_t SEG_4 = 7'b0011001;
    localparam seg_t SEG_5 = 7'b0010010;
    localparam seg_t SEG_6 = 7'b0000010;
    localparam seg_t SEG_7 = 7'b1111000;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0010000;
    localparam seg_t SEG_E = 7'b0000110;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam logic [9:0][6:0] SEG_LUT = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/bcd_display_mux_if.sv
// bcd_display_mux_if: load/data inputs and multiplexed display outputs of the BCD display
interface bcd_display_mux_if;
    import bcd_disp_pkg::*;
    logic load;
    logic [11:0] bcd_in;
    logic carry_in;
    seg_t seg;
    logic [DIGITS-1:0] an;
    logic err;
    modport master(output load, bcd_in, carry_in, input seg, an, err);
    modport slave(input load, bcd_in, carry_in, output seg, an, err);
endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: nibble plus blank flag to active-low segment pattern, E for non-BCD nibbles
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output seg_t       seg
);
    always_comb begin
        seg = blank ? SEG_BLANK : nib > BCD_MAX ? SEG_E : SEG_LUT[nib];
    end
endmodule

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: 4-digit scanned BCD display; leading-zero blanking under BCD_LEADING_ZERO_BLANK_EN
module bcd_display_mux
    import bcd_disp_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input logic clk,
    input logic rst,
    bcd_display_mux_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    logic [1:0] idx;
    logic [1:0] nidx;
    logic [11:0] d;
    logic c;
    logic tick;
    logic [3:0] nib;
    logic blank;
    seg_t dec;
    assign tick = cnt == CW'(CLK_DIV - 1);
    assign nidx = idx + 2'd1;
    assign bus.err = d[3:0] > BCD_MAX || d[7:4] > BCD_MAX || d[11:8] > BCD_MAX;
    // Decode uses the pre-edge latch, so a coincident load shows from the next tick.
    always_comb begin
        nib = nidx == 2'd0 ? d[3:0] : nidx == 2'd1 ? d[7:4] : nidx == 2'd2 ? d[11:8] : {3'b000, c};
`ifdef BCD_LEADING_ZERO_BLANK_EN
        blank = nidx == 2'd3 ? !c : nidx == 2'd2 ? !c && d[11:8] == 4'd0 : nidx == 2'd1 ? !c && d[11:4] == 8'd0 : 1'b0;
`else
        blank = 1'b0;
`endif
    end
    bcd_to_7seg u_dec (.nib(nib), .blank(blank), .seg(dec));
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd3;
            d <= '0;
            c <= 1'b0;
            bus.seg <= SEG_BLANK;
            bus.an <= '1;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (bus.load) begin
                d <= bus.bcd_in;
                c <= bus.carry_in;
            end
            if (tick) begin
                idx <= nidx;
                bus.seg <= dec;
                bus.an <= ~(4'b0001 << nidx);
            end
        end
    end
endmodule

// File: tb/tb_bcd_display_mux.sv
// tb_bcd_display_mux: directed checks of reset, scan order, err, coincident load/tick, blanking and mid-scan reset
module tb_bcd_display_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    bcd_display_mux_if bus ();
    bcd_display_mux #(.CLK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic nxt(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.load = 1'b0;
        end
        chk({tag, "_an"}, 32'(bus.an), 32'(an_e));
        chk({tag, "_seg"}, 32'(bus.seg), 32'(seg_e));
    endtask
    initial begin
        bus.load = 1'b0;
        bus.bcd_in = '0;
        bus.carry_in = 1'b0;
        step();
        step();
        chk("rst_an", 32'(bus.an), 32'hf);
        chk("rst_seg", 32'(bus.seg), 32'h7f);
        chk("rst_err", 32'(bus.err), 32'h0);
        rst = 1'b0;
        bus.load = 1'b1;
        bus.bcd_in = 12'h120;
        bus.carry_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.load = 1'b0;
            chk("pre_tick_an", 32'(bus.an), 32'hf);
            chk("pre_tick_seg", 32'(bus.seg), 32'h7f);
        end
        step();
        chk("tick0_an", 32'(bus.an), 32'he);
        chk("tick0_seg", 32'(bus.seg), 32'b1000000);
        step();
        step();
        step();
        chk("hold_an", 32'(bus.an), 32'he);
        step();
        chk("tens_an", 32'(bus.an), 32'hd);
        chk("tens_seg", 32'(bus.seg), 32'b0100100);
        nxt("hund", 4'b1011, 7'b1111001);
        nxt("thou", 4'b0111, 7'b1111001);
        nxt("wrap", 4'b1110, 7'b1000000);
        chk("valid_err", 32'(bus.err), 32'h0);
        bus.load = 1'b1;
        bus.bcd_in = 12'h1a3;
        bus.carry_in = 1'b0;
        nxt("bad_tens", 4'b1101, 7'b0000110);
        chk("bad_err", 32'(bus.err), 32'h1);
        nxt("bad_hund", 4'b1011, 7'b1111001);
        bus.load = 1'b1;
        bus.bcd_in = 12'h111;
        nxt("fix_thou", 4'b0111, LZ);
        chk("fix_err", 32'(bus.err), 32'h0);
        step();
        step();
        step();
        bus.load = 1'b1;
        bus.bcd_in = 12'h099;
        step();
        bus.load = 1'b0;
        chk("coin_an", 32'(bus.an), 32'he);
        chk("coin_seg", 32'(bus.seg), 32'b1111001);
        nxt("coin_tens", 4'b1101, 7'b0010000);
        nxt("coin_hund", 4'b1011, LZ);
        bus.load = 1'b1;
        bus.bcd_in = 12'h009;
        nxt("lz_thou", 4'b0111, LZ);
        nxt("lz_unit", 4'b1110, 7'b0010000);
        nxt("lz_tens", 4'b1101, LZ);
        nxt("lz_hund", 4'b1011, LZ);
        rst = 1'b1;
        bus.load = 1'b1;
        bus.bcd_in = 12'h1a3;
        step();
        rst = 1'b0;
        bus.load = 1'b0;
        chk("mid_rst_an", 32'(bus.an), 32'hf);
        chk("mid_rst_seg", 32'(bus.seg), 32'h7f);
        chk("mid_rst_err", 32'(bus.err), 32'h0);
        step();
        step();
        step();
        chk("post_rst_an", 32'(bus.an), 32'hf);
        step();
        chk("post_rst_tick_an", 32'(bus.an), 32'he);
        chk("post_rst_tick_seg", 32'(bus.seg), 32'b1000000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50000, giving clk cycles per digit-refresh tick (legal range 2..2^20).
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port load  input  1  one-cycle strobe that captures bcd_in and carry_in.
REQ-005 SHALL provide port bcd_in  input  12  three BCD digits from the adder result: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 SHALL provide port carry_in  input  1  adder carry-out, shown as the thousands digit.
REQ-007 SHALL provide port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL provide port an  output  4  digit anodes, active-low one-hot; an[0] is units, an[3] is thousands.
REQ-009 SHALL provide port err  output  1  high while the latched value holds any nibble greater than 9.

Function
REQ-010 SHALL run a prescaler counting 0..CLK_DIV-1, asserting an internal tick on the cycle the count equals CLK_DIV-1, then wrapping to 0.
REQ-011 SHALL keep a 2-bit scan index that advances by one on each tick and wraps from 3 to 0.
REQ-012 SHALL latch bcd_in and carry_in on any cycle where load=1, independent of prescaler and scan state.
REQ-013 SHALL not restart the prescaler or scan index on load.
REQ-014 SHALL register seg and an; both update on the edge where the tick is asserted.
REQ-015 SHALL decode on that edge the digit at the new scan index, using latched data from before that edge.
REQ-016 SHALL apply load and tick on the same edge as follows: the new data is latched, and the display shows it from the following tick.
REQ-017 SHALL show digit 3 as "1" when latched carry=1, otherwise as "0" (subject to REQ-025).
REQ-018 SHALL use these segment patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110, blank=1111111.
REQ-019 SHALL display "E" for any latched nibble in the range 10..15.
REQ-020 SHALL update err combinationally from the latched registers: high if any latched nibble exceeds 9, cleared by the next valid load.

Reset
REQ-021 SHALL, with rst=1 at a clock edge, clear the prescaler, the scan index (to 3, so the first tick selects digit 0), the latched data and the carry.
REQ-022 SHALL drive an=1111, seg=1111111 and err=0 from reset until the first tick.
REQ-023 SHALL make rst take priority over load and tick on the same edge, including reset applied mid-scan.

Configuration
REQ-024 SHALL compile leading-zero blanking in only when macro BCD_LEADING_ZERO_BLANK_EN is defined.
REQ-025 SHALL, with BCD_LEADING_ZERO_BLANK_EN defined, blank:
- digit 3 when carry=0;
- digit 2 when carry=0 and hundreds=0;
- digit 1 when carry=0, hundreds=0 and tens=0.
Digit 0 is never blanked, and "E" nibbles count as non-zero.
REQ-026 SHALL, without BCD_LEADING_ZERO_BLANK_EN, show all four digits at all times.

Structure
REQ-027 SHALL place the segment pattern constants, the digit count (4) and the BCD max value (9) in shared package bcd_disp_pkg.
REQ-028 SHALL instantiate one combinational sub-module bcd_to_7seg, which maps a 4-bit nibble plus a blank flag to a 7-bit active-low pattern.

Verification (CLK_DIV=4)
REQ-029 SHALL check reset: rst for 2 cycles, then release -> an=1111 and seg=1111111 for 4 cycles; at the first tick an=1110.
REQ-030 SHALL check a full scan: load bcd_in=12'h120, carry_in=1 -> scan shows units 0 (1000000), tens 2 (0100100), hundreds 1 (1111001), thousands 1 (1111001), an=1110,1101,1011,0111, each held 4 cycles, then the scan wraps.
REQ-031 SHALL check invalid input: load bcd_in=12'h1A3 -> err=1 and the tens digit shows 0000110; a subsequent load of 12'h111 -> err=0.
REQ-032 SHALL check load coincident with tick: load 12'h099 on a tick edge -> the digit shown at that edge uses the old data; the new data appears from the next tick.
REQ-033 SHALL check blanking with BCD_LEADING_ZERO_BLANK_EN: load 12'h009, carry_in=0 -> digits 3..1 show 1111111 and digit 0 shows 9. Without the macro, the same stimulus shows "0009".
REQ-034 SHALL check reset mid-scan: assert rst while an=1011 -> the next edge gives an=1111, seg=1111111, err=0.
